data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-side responder for the single-cycle core's data-memory interface. It accepts the core's write enable, address and write data, and returns read data combinationally in the same cycle. It decodes the address into:
- a word-addressed data RAM
- a small MMIO window holding a byte-wide TX FIFO (drained by an external valid/ready sink), a status register and a free-running cycle counter.

It sits beside the core in the top level, opposite the core's data port.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of two, at least 2.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window; 16-byte aligned.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
data_mem_write_enable  input  1  write strobe from core; active for one cycle per store.
data_mem_addr  input  32  byte address from core (its ALU result).
data_mem_write_data  input  32  store data from core.
data_mem_read_data  output  32  load data to core; combinational from address and current state.
tx_valid  output  1  FIFO head valid (FIFO not empty).
tx_data  output  8  FIFO head byte.
tx_ready  input  1  sink accepts the head byte when tx_valid and tx_ready are both high at a rising edge.

Behaviour:
- Reset (reset=0, asynchronous): FIFO read/write pointers and count = 0; overflow flag = 0; cycle counter = 0; tx_valid=0; tx_data=0.
  - RAM contents are not reset; they are undefined until written.
  - data_mem_read_data follows the decode below; after reset it reads 0 at MMIO TX_DATA, 32'h0000_0002 at STATUS and 0 at CYCLE.
- Address decode: address bits [1:0] are ignored (word accesses only).
  - RAM region: addr < RAM_WORDS*4. Index = addr[log2(RAM_WORDS)+1:2].
  - MMIO region: addr[31:4] == MMIO_BASE[31:4]. Offset = addr[3:2].
  - All other addresses: reads return 0; writes are ignored.
- RAM:
  - Write is synchronous: mem[index] <= write_data at the edge when write_enable is high.
  - Read is combinational from the current array. A read of the address being written in the same cycle returns the old value.
- MMIO offset 0, TX_DATA:
  - Write pushes write_data[7:0] when the FIFO is not full.
  - If the FIFO is full at the start of the cycle, the push is dropped and the overflow flag is set. This holds even if a pop occurs in the same cycle.
  - Read returns 0.
- MMIO offset 1, STATUS (read):
  - bit0 = full, bit1 = empty, bit2 = overflow, bits[7:3] = count, other bits 0.
  - Any write to STATUS clears overflow. If a drop and a STATUS write occur in the same cycle, the set wins.
- MMIO offset 2, CYCLE:
  - Counter increments by 1 every cycle out of reset and wraps from 32'hFFFF_FFFF to 0.
  - A write loads write_data, and the write takes priority over the increment that cycle.
  - Read returns the current value.
- MMIO offset 3: reads 0, writes ignored.
- FIFO:
  - tx_valid = (count != 0). tx_data = head entry, or 0 when empty.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push (not full) and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Latency:
  - Loads: 0 cycles (combinational).
  - Stores and pushes: visible one cycle later.
  - A pushed byte appears on tx_valid/tx_data the cycle after the push edge.
- Reset asserted mid-operation: FIFO empties and the counter clears immediately. Any in-flight push is lost.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x10, then read 0x10 and 0x13 -> 32'hDEADBEEF both. Read 0x14 before any write -> not checked. Read address RAM_WORDS*4 -> 0.
- FIFO fill/drain with tx_ready=0: push 0x41,0x42,0x43,0x44.
  - STATUS -> full=1, count=4.
  - A 5th push (0x45) is dropped and STATUS bit2=1.
  - Raise tx_ready -> bytes 0x41..0x44 emitted in order on 4 consecutive edges, then tx_valid=0 and STATUS=32'h2.
- Concurrent push/pop: count=2, tx_ready=1, push 0x55 -> count stays 2; 0x55 emitted third.
- Full + pop same cycle: count=4, tx_ready=1, push 0x66 -> push dropped, overflow=1, count=3.
- Overflow clear: write STATUS -> next cycle bit2=0.
- CYCLE:
  - Write 32'hFFFF_FFFE -> reads FFFF_FFFE then FFFF_FFFF then 0 on successive cycles.
  - Assert reset mid-run -> CYCLE=0, tx_valid=0 immediately, no clock needed.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: word RAM plus MMIO TX FIFO, status and cycle counter
module data_mem_responder #(
  parameter int unsigned      RAM_WORDS  = 64,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [31:0]      MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [1:0] OFF_TX_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;

  logic [31:0]      mem [RAM_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cycle_q, cycle_d;

  logic             ram_hit, mmio_hit;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       mmio_off;
  logic             full, empty;
  logic             push_req, push, drop, pop;
  logic             status_wr, cycle_wr;
  logic [31:0]      status_word;

  // Address decode and FIFO control strobes; full is judged on start-of-cycle count
  always_comb begin
    ram_hit     = (data_mem_addr < RAM_BYTES);
    mmio_hit    = (data_mem_addr[31:4] == MMIO_BASE[31:4]);
    ram_idx     = data_mem_addr[IDX_W+1:2];
    mmio_off    = data_mem_addr[3:2];
    full        = (count_q == CNT_W'(FIFO_DEPTH));
    empty       = (count_q == '0);
    push_req    = data_mem_write_enable && mmio_hit && (mmio_off == OFF_TX_DATA);
    push        = push_req && !full;
    drop        = push_req && full;
    pop         = !empty && tx_ready;
    status_wr   = data_mem_write_enable && mmio_hit && (mmio_off == OFF_STATUS);
    cycle_wr    = data_mem_write_enable && mmio_hit && (mmio_off == OFF_CYCLE);
    status_word = {24'd0, 5'(count_q), ovf_q, empty, full};
  end

  // Next-state for FIFO pointers, overflow flag (set beats clear) and cycle counter (load beats increment)
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (status_wr) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
    cycle_d  = cycle_wr ? data_mem_write_data : cycle_q + 32'd1;
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycle_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
    end
  end

  // Storage arrays are not reset; FIFO output is masked while empty
  always_ff @(posedge clk) begin
    if (data_mem_write_enable && ram_hit) mem[ram_idx] <= data_mem_write_data;
    if (push) fifo_mem[wr_ptr_q] <= data_mem_write_data[7:0];
  end

  // Combinational load path and FIFO head presentation
  always_comb begin
    data_mem_read_data = 32'd0;
    if (ram_hit) begin
      data_mem_read_data = mem[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_STATUS: data_mem_read_data = status_word;
        OFF_CYCLE:  data_mem_read_data = cycle_q;
        default:    data_mem_read_data = 32'd0;
      endcase
    end
    tx_valid = !empty;
    tx_data  = empty ? 8'd0 : fifo_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam logic [31:0] A_TX     = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_OFF3   = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic        data_mem_write_enable;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_write_data;
  logic [31:0] data_mem_read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks;
  int failures;

  data_mem_responder #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(4),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .data_mem_write_enable(data_mem_write_enable),
    .data_mem_addr        (data_mem_addr),
    .data_mem_write_data  (data_mem_write_data),
    .data_mem_read_data   (data_mem_read_data),
    .tx_valid             (tx_valid),
    .tx_data              (tx_data),
    .tx_ready             (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    data_mem_addr = addr;
    #1;
    check(tag, data_mem_read_data, exp);
  endtask

  // One store occupying one full cycle; returns at the following falling edge
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    data_mem_write_enable = 1'b1;
    data_mem_addr         = addr;
    data_mem_write_data   = data;
    @(negedge clk);
    data_mem_write_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    tx_ready = 1'b0;
    data_mem_write_enable = 1'b0;
    data_mem_addr         = 32'd0;
    data_mem_write_data   = 32'd0;

    // Reset state
    #12;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk_read("rst_status", A_STATUS, 32'h2);
    chk_read("rst_cycle", A_CYCLE, 32'h0);
    chk_read("rst_txdata_rd", A_TX, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // RAM write/read, byte-offset ignore, out-of-range
    do_write(32'h10, 32'hDEAD_BEEF);
    chk_read("ram_rd_10", 32'h10, 32'hDEAD_BEEF);
    chk_read("ram_rd_13", 32'h13, 32'hDEAD_BEEF);
    chk_read("ram_past_end", 32'h100, 32'h0);
    chk_read("unmapped_rd", 32'h8000_0000, 32'h0);
    @(negedge clk);
    data_mem_write_enable = 1'b1;
    data_mem_addr         = 32'h10;
    data_mem_write_data   = 32'h1234_5678;
    #1;
    check("ram_rd_during_wr", data_mem_read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    data_mem_write_enable = 1'b0;
    chk_read("ram_rd_after_wr", 32'h10, 32'h1234_5678);

    // MMIO offset 3 ignores writes
    do_write(A_OFF3, 32'hFFFF_FFFF);
    chk_read("off3_rd", A_OFF3, 32'h0);

    // Fill FIFO with sink stalled
    for (int i = 0; i < 4; i++) do_write(A_TX, 32'h41 + i);
    chk_read("fill_status", A_STATUS, 32'h21);
    chk_read("txdata_reads_zero", A_TX, 32'h0);
    check("fill_head", {24'd0, tx_data}, 32'h41);
    do_write(A_TX, 32'h45);
    chk_read("drop_status", A_STATUS, 32'h25);
    check("stall_head_held", {24'd0, tx_data}, 32'h41);

    // Drain on four consecutive edges
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", {31'd0, tx_valid}, 32'd1);
      check("drain_byte", {24'd0, tx_data}, 32'h41 + i);
      @(negedge clk);
    end
    #1;
    check("drained_valid", {31'd0, tx_valid}, 32'd0);
    check("drained_data", {24'd0, tx_data}, 32'd0);
    chk_read("drained_status_ovf", A_STATUS, 32'h6);
    tx_ready = 1'b0;
    do_write(A_STATUS, 32'h0);
    chk_read("ovf_cleared", A_STATUS, 32'h2);

    // Concurrent push and pop at count 2
    do_write(A_TX, 32'h51);
    do_write(A_TX, 32'h52);
    chk_read("cnt2_status", A_STATUS, 32'h10);
    @(negedge clk);
    tx_ready              = 1'b1;
    data_mem_write_enable = 1'b1;
    data_mem_addr         = A_TX;
    data_mem_write_data   = 32'h55;
    #1;
    check("pp_head_before", {24'd0, tx_data}, 32'h51);
    @(negedge clk);
    data_mem_write_enable = 1'b0;
    tx_ready              = 1'b0;
    chk_read("pp_count_same", A_STATUS, 32'h10);
    check("pp_second", {24'd0, tx_data}, 32'h52);
    tx_ready = 1'b1;
    @(negedge clk);
    #1;
    check("pp_third", {24'd0, tx_data}, 32'h55);
    @(negedge clk);
    #1;
    check("pp_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Full plus pop in the same cycle: push still dropped
    for (int i = 0; i < 4; i++) do_write(A_TX, 32'h61 + i);
    @(negedge clk);
    tx_ready              = 1'b1;
    data_mem_write_enable = 1'b1;
    data_mem_addr         = A_TX;
    data_mem_write_data   = 32'h66;
    @(negedge clk);
    data_mem_write_enable = 1'b0;
    tx_ready              = 1'b0;
    chk_read("fullpop_status", A_STATUS, 32'h1C);
    do_write(A_TX, 32'h67);
    do_write(A_STATUS, 32'h0);
    chk_read("refill_clear", A_STATUS, 32'h21);
    exp_bytes[0] = 8'h62; exp_bytes[1] = 8'h63; exp_bytes[2] = 8'h64; exp_bytes[3] = 8'h67;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fullpop_drain", {24'd0, tx_data}, {24'd0, exp_bytes[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;

    // Cycle counter load and wrap
    do_write(A_CYCLE, 32'hFFFF_FFFE);
    chk_read("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
    @(negedge clk);
    chk_read("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    @(negedge clk);
    chk_read("cycle_wrap", A_CYCLE, 32'h0);
    @(negedge clk);
    chk_read("cycle_inc", A_CYCLE, 32'h1);

    // Asynchronous reset mid-run
    do_write(A_TX, 32'h77);
    #1;
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    #1;
    reset = 1'b0;
    chk_read("async_rst_cycle", A_CYCLE, 32'h0);
    check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk_read("async_rst_status", A_STATUS, 32'h2);
    @(negedge clk);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
